// File: rtl/period_generator.sv
// Phase-accumulator clock synthesizer: builds a 50%-duty clk_out of a requested period (ps) from clk.
// Optional deferred (glitch-free) reload is enabled by defining PERIOD_GENERATOR_GLITCHFREE_EN.
module period_generator #(
    parameter int unsigned CLK_PERIOD_1000 = 10000,  // system clock period in ps, must be > 0
    parameter int unsigned LOCK_CYCLES     = 4       // 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] period_1000,
    input  logic        load,
    output logic        clk_out,
    output logic        locked,
    output logic        invalid,
    output logic [31:0] active_period_1000
);

    localparam logic [32:0] INC         = 33'(CLK_PERIOD_1000) << 1;
    localparam logic [7:0]  LOCK_TARGET = 8'(LOCK_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StLocked, StInvalid} state_e;

    state_e      state_q;
    logic [32:0] acc_q;
    logic [7:0]  lock_cnt_q;

    logic [32:0] sum;
    logic [32:0] period_ext;
    logic        wrap;
    logic        load_valid;
    logic        running;
    logic        do_start;
    logic [31:0] start_period;
    logic        start_valid;

`ifdef PERIOD_GENERATOR_GLITCHFREE_EN
    logic        pending_q;
    logic [31:0] pending_period_q;
    logic        pend_set;
    logic        pend_clr;
`endif

    always_comb begin
        sum          = acc_q + INC;
        period_ext   = {1'b0, active_period_1000};
        wrap         = (sum >= period_ext);
        load_valid   = ({1'b0, period_1000} >= INC);
        running      = (state_q == StRun) || (state_q == StLocked);
        do_start     = load;
        start_period = period_1000;
        start_valid  = load_valid;
`ifdef PERIOD_GENERATOR_GLITCHFREE_EN
        pend_set = 1'b0;
        pend_clr = 1'b0;
        // A valid reload during a high phase waits for the next falling edge.
        if (load && load_valid && running && clk_out) begin
            if (wrap) begin
                pend_clr = 1'b1;
            end else begin
                do_start = 1'b0;
                pend_set = 1'b1;
            end
        end else if (load) begin
            pend_clr = 1'b1;
        end else if (pending_q && running && clk_out && wrap) begin
            do_start     = 1'b1;
            start_period = pending_period_q;
            start_valid  = 1'b1;
            pend_clr     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= StIdle;
            acc_q              <= '0;
            lock_cnt_q         <= '0;
            clk_out            <= 1'b0;
            locked             <= 1'b0;
            invalid            <= 1'b0;
            active_period_1000 <= '0;
        end else if (do_start) begin
            acc_q              <= '0;
            lock_cnt_q         <= '0;
            clk_out            <= 1'b0;
            locked             <= 1'b0;
            invalid            <= ~start_valid;
            active_period_1000 <= start_valid ? start_period : 32'd0;
            state_q            <= start_valid ? StRun : StInvalid;
        end else if (running) begin
            if (wrap) begin
                acc_q   <= sum - period_ext;
                clk_out <= ~clk_out;
                // Count rising edges only while still acquiring lock.
                if (!clk_out && state_q == StRun) begin
                    if (lock_cnt_q != 8'hFF) begin
                        lock_cnt_q <= lock_cnt_q + 8'd1;
                    end
                    if (lock_cnt_q + 8'd1 == LOCK_TARGET) begin
                        state_q <= StLocked;
                        locked  <= 1'b1;
                    end
                end
            end else begin
                acc_q <= sum;
            end
        end
    end

`ifdef PERIOD_GENERATOR_GLITCHFREE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q        <= 1'b0;
            pending_period_q <= '0;
        end else if (pend_set) begin
            pending_q        <= 1'b1;
            pending_period_q <= period_1000;
        end else if (pend_clr) begin
            pending_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_period_generator.sv
// Self-checking bench for period_generator: closed-form reference model (toggles = floor(n*INC/P)).
module tb_period_generator;

    localparam int unsigned CLKP     = 10000;
    localparam int unsigned BIG_CLKP = 50000;
    localparam int unsigned LOCKN    = 4;
    localparam longint      INC      = 2 * CLKP;
    localparam longint      BIG_INC  = 2 * BIG_CLKP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        big_load = 1'b0;
    logic [31:0] period_1000 = '0;
    logic        clk_out, locked, invalid;
    logic [31:0] active_period_1000;
    logic        big_clk_out, big_locked, big_invalid;
    logic [31:0] big_active;

    int total = 0;
    int bad = 0;

    period_generator #(.CLK_PERIOD_1000(CLKP), .LOCK_CYCLES(LOCKN)) dut (
        .clk(clk), .reset(reset), .period_1000(period_1000), .load(load),
        .clk_out(clk_out), .locked(locked), .invalid(invalid),
        .active_period_1000(active_period_1000)
    );

    period_generator #(.CLK_PERIOD_1000(BIG_CLKP), .LOCK_CYCLES(LOCKN)) big_dut (
        .clk(clk), .reset(reset), .period_1000(period_1000), .load(big_load),
        .clk_out(big_clk_out), .locked(big_locked), .invalid(big_invalid),
        .active_period_1000(big_active)
    );

    always #5 clk = ~clk;

    // Expected {clk_out, locked, invalid, active} n clock edges after the load edge.
    function automatic logic [34:0] model_out(input longint p, input longint inc, input longint n);
        longint t;
        logic   co, lk;
        if (p < inc) return {1'b0, 1'b0, 1'b1, 32'd0};
        t  = (n * inc) / p;
        co = t[0];
        lk = ((t + 1) / 2) >= LOCKN;
        return {co, lk, 1'b0, 32'(p)};
    endfunction

    task automatic drive_load(input logic [31:0] p);
        @(negedge clk);
        period_1000 = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] obs;
        @(negedge clk);
        reset = 1'b1;
        load = 1'b1;
        big_load = 1'b1;
        period_1000 = 32'd40000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        load = 1'b0;
        big_load = 1'b0;
        obs = {clk_out, locked, invalid, active_period_1000};
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL reset got=%h want=0", obs);
        end
        obs = {big_clk_out, big_locked, big_invalid, big_active};
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL reset_big got=%h want=0", obs);
        end
    endtask

    task automatic test_integer_period();
        logic [34:0] obs, exp;
        int first_rise = -1;
        int first_lock = -1;
        drive_load(32'd40000);
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) @(negedge clk);
            obs = {clk_out, locked, invalid, active_period_1000};
            exp = model_out(40000, INC, n);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL int_period n=%0d got=%h want=%h", n, obs, exp);
            end
            if (clk_out && first_rise < 0) first_rise = n;
            if (locked && first_lock < 0) first_lock = n;
        end
        total++;
        if (first_rise !== 2) begin
            bad++;
            $display("FAIL first_rise got=%0d want=2", first_rise);
        end
        total++;
        if (first_lock !== 14) begin
            bad++;
            $display("FAIL lock_edge got=%0d want=14", first_lock);
        end
    endtask

    task automatic test_fractional();
        logic [34:0] obs, exp;
        logic prev;
        int toggles = 0;
        int rises = 0;
        int first_r = -1;
        int last_r = -1;
        longint avg;
        drive_load(32'd30000);
        prev = clk_out;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) @(negedge clk);
            obs = {clk_out, locked, invalid, active_period_1000};
            exp = model_out(30000, INC, n);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL frac n=%0d got=%h want=%h", n, obs, exp);
            end
            if (n > 0 && n <= 20 && clk_out != prev) toggles++;
            if (n > 0 && clk_out && !prev) begin
                rises++;
                if (first_r < 0) first_r = n;
                last_r = n;
            end
            prev = clk_out;
        end
        total++;
        if (toggles !== 13) begin
            bad++;
            $display("FAIL frac_toggles got=%0d want=13", toggles);
        end
        avg = (rises > 1) ? (longint'(last_r - first_r) * CLKP) / (rises - 1) : 0;
        total++;
        if (avg !== 64'd30000) begin
            bad++;
            $display("FAIL frac_avg_period got=%0d want=30000", avg);
        end
    endtask

    task automatic test_invalid();
        logic [34:0] obs, exp;
        logic [31:0] plist[3] = '{32'd15000, 32'd0, 32'd20000};
        for (int k = 0; k < 3; k++) begin
            drive_load(plist[k]);
            for (int n = 0; n <= 10; n++) begin
                if (n > 0) @(negedge clk);
                obs = {clk_out, locked, invalid, active_period_1000};
                exp = model_out(longint'(plist[k]), INC, n);
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL invalid p=%0d n=%0d got=%h want=%h", plist[k], n, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reload_locked();
        logic [34:0] obs, exp;
        drive_load(32'd40000);
        repeat (16) @(negedge clk);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL pre_reload_lock got=%b want=1", locked);
        end
        drive_load(32'd60000);
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) @(negedge clk);
            obs = {clk_out, locked, invalid, active_period_1000};
            exp = model_out(60000, INC, n);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reload n=%0d got=%h want=%h", n, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] obs, exp;
        logic [31:0] p1, p2;
        for (int it = 0; it < 4; it++) begin
            p1 = $urandom_range(120000, 20000);
            p2 = $urandom_range(120000, 20000);
            @(negedge clk);
            period_1000 = p1;
            load = 1'b1;
            @(negedge clk);
            period_1000 = p2;
            @(negedge clk);
            load = 1'b0;
            for (int n = 0; n <= 25; n++) begin
                if (n > 0) @(negedge clk);
                obs = {clk_out, locked, invalid, active_period_1000};
                exp = model_out(longint'(p2), INC, n);
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL b2b p=%0d n=%0d got=%h want=%h", p2, n, obs, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [34:0] obs, exp;
        logic [31:0] p;
        int len;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(4, 0) == 0) p = $urandom_range(19999, 0);
            else p = $urandom_range(200000, 20000);
            len = $urandom_range(60, 5);
            drive_load(p);
            for (int n = 0; n <= len; n++) begin
                if (n > 0) @(negedge clk);
                obs = {clk_out, locked, invalid, active_period_1000};
                exp = model_out(longint'(p), INC, n);
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL random p=%0d n=%0d got=%h want=%h", p, n, obs, exp);
                end
            end
        end
    endtask

    task automatic test_huge();
        logic [34:0] obs, exp;
        longint p = 64'd4294967295;
        longint want;
        int n;
        drive_load(32'hFFFF_FFFF);
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) @(negedge clk);
            obs = {clk_out, locked, invalid, active_period_1000};
            exp = model_out(p, INC, k);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL huge n=%0d got=%h want=%h", k, obs, exp);
            end
        end
        @(negedge clk);
        period_1000 = 32'hFFFF_FFFF;
        big_load = 1'b1;
        @(negedge clk);
        big_load = 1'b0;
        n = 0;
        while (!big_clk_out && n < 50000) begin
            @(negedge clk);
            n++;
        end
        want = (p + BIG_INC - 1) / BIG_INC;
        total++;
        if (longint'(n) !== want) begin
            bad++;
            $display("FAIL huge_first_toggle got=%0d want=%0d", n, want);
        end
        total++;
        if (big_active !== 32'hFFFF_FFFF || big_invalid !== 1'b0) begin
            bad++;
            $display("FAIL huge_active got=%h inv=%b want=ffffffff inv=0", big_active, big_invalid);
        end
    endtask

    initial begin
        test_reset();
        test_integer_period();
        test_fractional();
        test_invalid();
        test_reload_locked();
        test_back_to_back();
        test_random();
        test_huge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
